// File: rtl/trace_capture.sv
// trace_capture: retirement trace buffer with bubble filter, PC trigger and valid/ready drain.
// Define TRACE_SIGNATURE_EN to add the running result checksum port `signature`.
module trace_capture #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [31:0]      pc,
  input  logic [31:0]      instr,
  input  logic [31:0]      result,
  input  logic             trig_en,
  input  logic [31:0]      trig_pc,
  input  logic [PTR_W:0]   post_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_result,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             frozen
`ifdef TRACE_SIGNATURE_EN
  ,
  output logic [31:0]      signature
`endif
);

  localparam logic [31:0]    INSTR_NOP  = 32'h0000_0013;
  localparam logic [31:0]    INSTR_BUBL = 32'h0000_0000;
  localparam logic [PTR_W:0] FULL_CNT   = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, POST, FROZEN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] result;
  } entry_t;

  state_t           state, state_d;
  logic [PTR_W:0]   remaining, remaining_d;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  entry_t           mem [DEPTH];
  entry_t           head;

  logic capturing, qualify, full, pop, push, drop, trig_hit;

  assign capturing = (state == RUN) || (state == POST);
  assign qualify   = en && capturing && (instr != INSTR_NOP) && (instr != INSTR_BUBL);
  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full buffer still accepts when the head leaves on the same edge.
  assign push      = qualify && (!full || pop);
  assign drop      = qualify && full && !pop;
  assign trig_hit  = trig_en && (pc == trig_pc);
  assign frozen    = (state == FROZEN);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    unique case (state)
      IDLE: if (en) state_d = RUN;
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (qualify && trig_hit) begin
          remaining_d = post_cnt;
          state_d     = (post_cnt == '0) ? FROZEN : POST;
        end
      end
      POST: begin
        // Dropped samples count toward the post-trigger window too.
        if (qualify) begin
          remaining_d = remaining - (PTR_W + 1)'(1);
          if (remaining <= (PTR_W + 1)'(1)) state_d = FROZEN;
        end
      end
      FROZEN: ;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_d;
      remaining <= remaining_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef TRACE_SIGNATURE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      signature <= '0;
    end else if (push) begin
      signature <= {signature[30:0], signature[31]} ^ result;
    end
  end
`endif

  // NOTE: storage is not reset; outputs are gated by out_valid so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: pc, instr: instr, result: result};
  end

  assign head       = mem[rd_ptr];
  assign out_pc     = out_valid ? head.pc     : '0;
  assign out_instr  = out_valid ? head.instr  : '0;
  assign out_result = out_valid ? head.result : '0;

endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_trace_capture;
  localparam int          DEPTH = 16;
  localparam int          PTR_W = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic             clk;
  logic             rst, en, trig_en, out_ready;
  logic [31:0]      pc, instr, result, trig_pc;
  logic [PTR_W:0]   post_cnt;
  logic             out_valid, overflow, frozen;
  logic [31:0]      out_pc, out_instr, out_result;
  logic [PTR_W:0]   count;
`ifdef TRACE_SIGNATURE_EN
  logic [31:0]      signature;
`endif

  trace_capture #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .instr(instr), .result(result),
    .trig_en(trig_en), .trig_pc(trig_pc), .post_cnt(post_cnt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_result(out_result),
    .count(count), .overflow(overflow), .frozen(frozen)
`ifdef TRACE_SIGNATURE_EN
    , .signature(signature)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of stored triples plus the capture mode.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] result;
  } entry_t;
  typedef enum int {M_IDLE, M_RUN, M_POST, M_FROZEN} mode_t;

  entry_t      mq[$];
  mode_t       mmode;
  int          mrem;
  bit          movf;
  logic [31:0] msig;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop, qual, accept;
    if (rst) begin
      mq.delete();
      mmode = M_IDLE;
      mrem  = 0;
      movf  = 0;
      msig  = '0;
      return;
    end
    pop    = (mq.size() != 0) && out_ready;
    qual   = en && (mmode == M_RUN || mmode == M_POST) && instr != NOP && instr != 32'h0;
    accept = qual && (mq.size() < DEPTH || pop);
    if (qual && !accept) movf = 1;
    if (pop) void'(mq.pop_front());
    if (accept) begin
      mq.push_back('{pc, instr, result});
      msig = {msig[30:0], msig[31]} ^ result;
    end
    case (mmode)
      M_IDLE: if (en) mmode = M_RUN;
      M_RUN: begin
        if (!en) mmode = M_IDLE;
        else if (qual && trig_en && pc == trig_pc) begin
          mrem  = int'(post_cnt);
          mmode = (mrem == 0) ? M_FROZEN : M_POST;
        end
      end
      M_POST: if (qual) begin
        mrem--;
        if (mrem == 0) mmode = M_FROZEN;
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    check("count", 32'(count), 32'(mq.size()));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("overflow", 32'(overflow), 32'(movf));
    check("frozen", 32'(frozen), 32'(mmode == M_FROZEN));
    if (mq.size() != 0) begin
      check("out_pc", out_pc, mq[0].pc);
      check("out_instr", out_instr, mq[0].instr);
      check("out_result", out_result, mq[0].result);
    end
`ifdef TRACE_SIGNATURE_EN
    check("signature", signature, msig);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic sample(input logic e, input logic [31:0] p, input logic [31:0] i,
                        input logic [31:0] r);
    en = e; pc = p; instr = i; result = r;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; out_ready = 1'b0; trig_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // First enabled cycle only moves IDLE to RUN; nothing is captured on it.
  task automatic prime();
    sample(1'b1, 32'hFFFF_FF00, NOP, 32'h0);
  endtask

  task automatic drain(input int n);
    en = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < n; k++) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pc = '0; instr = '0; result = '0;
    trig_en = 1'b0; trig_pc = 32'h20; post_cnt = '0; out_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_count", 32'(count), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_frozen", 32'(frozen), 32'h0);

    // Bubble filter
    prime();
    sample(1'b1, 32'h104, NOP,          32'h11);
    sample(1'b1, 32'h108, 32'h00500093, 32'h22);
    sample(1'b1, 32'h10C, 32'h00000000, 32'h33);
    sample(1'b1, 32'h110, 32'h00a00113, 32'h44);
    en = 1'b0; tick();
    check("bubble_count", 32'(count), 32'd2);
    check("bubble_head0", out_pc, 32'h108);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("bubble_head1", out_pc, 32'h110);
    drain(2);

    // Fill and overflow
    do_reset();
    prime();
    for (int k = 0; k < 17; k++) sample(1'b1, 32'h200 + 32'(4 * k), 32'h1000_0000 | 32'(k), 32'(k));
    check("fill_count", 32'(count), 32'd16);
    check("fill_overflow", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    sample(1'b1, 32'h300, 32'h2000_0001, 32'hABCD);
    out_ready = 1'b0;
    check("full_pushpop_count", 32'(count), 32'd16);
    drain(15);
    check("fill_tail", out_pc, 32'h300);
    drain(1);

    // Trigger with post_cnt = 3
    do_reset();
    prime();
    trig_en = 1'b1; trig_pc = 32'h20; post_cnt = (PTR_W + 1)'(3);
    for (int k = 0; k < 16; k++) sample(1'b1, 32'(4 * k), 32'h3000_0000 | 32'(k), 32'(4 * k) ^ 32'hA5);
    check("trig3_count", 32'(count), 32'd12);
    check("trig3_frozen", 32'(frozen), 32'd1);
    trig_en = 1'b0;
    drain(11);
    check("trig3_last", out_pc, 32'h2C);
    drain(1);

    // Trigger with post_cnt = 0
    do_reset();
    prime();
    trig_en = 1'b1; post_cnt = '0;
    for (int k = 0; k < 12; k++) sample(1'b1, 32'(4 * k), 32'h4000_0000 | 32'(k), 32'(k));
    check("trig0_count", 32'(count), 32'd9);
    trig_en = 1'b0;
    drain(8);
    check("trig0_last", out_pc, 32'h20);
    drain(1);

    // Reset in the middle of POST
    do_reset();
    prime();
    trig_en = 1'b1; post_cnt = (PTR_W + 1)'(10);
    for (int k = 0; k < 5; k++) sample(1'b1, 32'h10 + 32'(4 * k), 32'h5000_0000 | 32'(k), 32'(k));
    check("post_count", 32'(count), 32'd5);
    trig_en = 1'b0;
    do_reset();
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    prime();
    sample(1'b1, 32'h400, 32'h6000_0000, 32'h1);
    sample(1'b1, 32'h404, 32'h6000_0001, 32'h2);
    check("resume_count", 32'(count), 32'd2);

`ifdef TRACE_SIGNATURE_EN
    do_reset();
    prime();
    sample(1'b1, 32'h500, 32'h7000_0000, 32'h1);
    check("sig_first", signature, 32'h1);
    sample(1'b1, 32'h504, 32'h7000_0001, 32'h2);
    check("sig_second", signature, 32'h0);
`endif

    // Randomized traffic with varying consumer pressure and occasional resets
    do_reset();
    trig_pc = 32'h20;
    for (int phase = 0; phase < 6; phase++) begin
      int ready_pct;
      ready_pct = (phase % 3 == 0) ? 10 : ((phase % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 500; c++) begin
        int sel;
        rst       = ($urandom_range(0, 149) == 0);
        en        = ($urandom_range(0, 9) != 0);
        pc        = 32'(4 * $urandom_range(0, 15));
        sel       = $urandom_range(0, 3);
        instr     = (sel == 0) ? NOP : ((sel == 1) ? 32'h0 : ($urandom | 32'h100));
        result    = $urandom;
        out_ready = ($urandom_range(0, 99) < ready_pct);
        trig_en   = ($urandom_range(0, 5) == 0);
        post_cnt  = (PTR_W + 1)'($urandom_range(0, 20));
        tick();
      end
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
# trace_capture

Retirement trace buffer that sits directly downstream of the pipelined CPU top and consumes its per-cycle `PC`/`Instr`/`Result` observation outputs. It filters pipeline bubbles, stores qualifying (PC, Instr, Result) triples in a circular buffer, and supports an optional PC-match trigger that freezes capture a programmable number of entries later. Stored entries drain through a valid/ready read port for a bench or debug host.

## Interface
- `DEPTH`, 16: buffer entries; power of two, at least 2.
- `PTR_W`, `$clog2(DEPTH)`: pointer width (derived; not overridden).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  capture enable; sampled every cycle.
- `pc`  in  32  CPU PC observation.
- `instr`  in  32  CPU instruction observation.
- `result`  in  32  CPU write-back result observation.
- `trig_en`  in  1  arm PC trigger.
- `trig_pc`  in  32  trigger PC value.
- `post_cnt`  in  PTR_W+1  entries still to capture after the trigger entry.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head.
- `out_pc`, `out_instr`, `out_result`  out  32 each  head entry fields.
- `count`  out  PTR_W+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: at least one qualifying sample dropped.
- `frozen`  out  1  high in FROZEN state.
- `signature`  out  32  running result checksum (only with `TRACE_SIGNATURE_EN`).

## Operation
- Qualifying sample: `en`=1, state RUN or POST, and `instr` is neither 32'h00000013 (NOP) nor 32'h00000000 (flush bubble).
- Push: qualifying sample writes {pc, instr, result} at wr_ptr; wr_ptr increments mod DEPTH.
- Pop: `out_valid && out_ready`; rd_ptr increments mod DEPTH.
- `out_valid` = (count != 0); `out_*` show-ahead from rd_ptr; `out_*` undefined-free: drive the stored value, 0 after reset.
- Full (count == DEPTH): push without a simultaneous pop is dropped and `overflow` set; push with a simultaneous pop is accepted and count stays DEPTH.
- Empty: `out_ready` ignored; push and pop never coincide on the same entry.
- FSM states: IDLE, RUN, POST, FROZEN.
  - IDLE -> RUN when `en`=1.
  - RUN -> IDLE when `en`=0.
  - RUN -> POST when a qualifying sample has `trig_en`=1 and `pc == trig_pc`; that sample is pushed and `post_cnt` is loaded into the remaining counter. If `post_cnt` == 0, go straight to FROZEN.
  - POST: each pushed qualifying sample decrements remaining; the sample taking it to 0 is pushed and the next state is FROZEN. Dropped samples on full still decrement.
  - FROZEN: no pushes; pops continue; leaves only on `rst`.
- `en`=0 in POST holds state and remaining (no IDLE exit).
- Trigger match in POST or FROZEN is ignored.

## Timing
- Reset: state IDLE, pointers 0, `count` 0, `out_valid` 0, `out_*` 0, `overflow` 0, `frozen` 0, `signature` 0. Asserting `rst` mid-operation discards all entries on that edge.
- Push latency: sample captured at edge N appears on `out_*`/`count` after edge N when the buffer was empty (`out_valid` high in cycle N+1).
- Pop: head advances on the accepting edge; the next entry is visible the following cycle.
- `overflow` rises the cycle after the first drop; `frozen` rises the cycle after the final POST push.
- Throughput: one push and one pop per cycle.

## Configuration
- `TRACE_SIGNATURE_EN` defined: `signature` port exists; on every accepted push, signature <= {signature[30:0], signature[31]} ^ result. Drops do not update it; reset to 0.
- Undefined: no `signature` port and no signature register; all other behaviour identical.

## Test plan
- Bubble filter: `en`=1, instrs 0x00000013, 0x00500093, 0x00000000, 0x00a00113 -> exactly 2 entries; count=2; heads PC order preserved.
- Fill/overflow, DEPTH=16: 17 qualifying pushes with `out_ready`=0 -> count=16, `overflow`=1, 17th sample absent; then one simultaneous push+pop at full -> count stays 16, new entry present.
- Trigger: `trig_pc`=0x00000020, `post_cnt`=3, continuous qualifying stream -> entries end exactly 3 after PC 0x20; `frozen`=1; further samples ignored.
- Trigger with `post_cnt`=0 -> the PC 0x20 entry is the last stored; FROZEN the next cycle.
- Reset mid-POST, with 5 entries stored -> next cycle count=0, `out_valid`=0, IDLE; capture resumes after `en`.
- Signature (macro on): results 1, 2 pushed -> signature 0x00000000 ^ 1 = 1, then {rotl(1)} ^ 2 = 0x00000000.
